// File: rtl/route_mask_ctrl_if.sv
// ---------------------------------------------------------------------------
// route_mask_ctrl_if
//
// Purpose : Groups the data-path handshake between the upstream producer,
//           route_mask_ctrl and the route-distributor chain.
//
// Signals :
//   in_data  [DIN_W]   data word from the producer
//   in_vld             in_data valid
//   in_rdy             route_mask_ctrl accepts in_data
//   din_vec  [DIN_W]   registered data word to the distributor chain
//   sw_vec   [DOUT_W]  active lane-switch mask (sw_vec[i] -> chain cell i)
//   out_vld            din_vec valid
//   out_rdy            distributor chain accepts din_vec
//
// Modports:
//   slave  : route_mask_ctrl side
//   master : producer / consumer (testbench) side
// ---------------------------------------------------------------------------
interface route_mask_ctrl_if #(
  parameter int DIN_W  = 70,
  parameter int DOUT_W = 128
);

  logic [DIN_W-1:0]  in_data;
  logic              in_vld;
  logic              in_rdy;
  logic [DIN_W-1:0]  din_vec;
  logic [DOUT_W-1:0] sw_vec;
  logic              out_vld;
  logic              out_rdy;

  modport slave (
    input  in_data, in_vld, out_rdy,
    output in_rdy, din_vec, sw_vec, out_vld
  );

  modport master (
    output in_data, in_vld, out_rdy,
    input  in_rdy, din_vec, sw_vec, out_vld
  );

endinterface

// File: rtl/route_mask_ctrl.sv
// ---------------------------------------------------------------------------
// route_mask_ctrl
//
// Purpose : Control and data-staging stage in front of the route-distributor
//           combinational chain. A DOUT_W-bit lane-switch mask is shifted in
//           serially, its population count is validated, and on success it is
//           committed to sw_vec. Data words are accepted through a
//           valid/ready handshake and presented, registered, on din_vec
//           together with the stable sw_vec.
//
// Parameters:
//   DIN_W   data word width; also the required mask popcount
//   DOUT_W  output lane count; also the mask length
//   CNT_W   bit / popcount counter width, 2**CNT_W must exceed DOUT_W
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   cfg_start    pulse: begin (or restart) a mask load
//   cfg_bit      serial mask bit, first bit lands in sw_vec[0]
//   cfg_bit_vld  cfg_bit qualifier
//   bus          route_mask_ctrl_if.slave: in_data/in_vld/in_rdy,
//                din_vec/sw_vec/out_vld/out_rdy
//   mask_ok      active mask committed and valid
//   mask_err     last load failed its popcount check
//   busy         high in LOAD, CHECK or DRAIN
//
// Optional feature (macro ROUTE_MASK_RELAX_EN):
//   When defined, CHECK accepts any popcount P with 1 <= P <= DIN_W, P is
//   kept, and din_vec bits [DIN_W-1:P] are forced to zero on every transfer
//   so unused distributor inputs are deterministic. When undefined only
//   P == DIN_W passes and din_vec is an unmodified copy of in_data.
// ---------------------------------------------------------------------------
module route_mask_ctrl #(
  parameter int DIN_W  = 70,
  parameter int DOUT_W = 128,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_bit,
  input  logic              cfg_bit_vld,
  route_mask_ctrl_if.slave  bus,
  output logic              mask_ok,
  output logic              mask_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state;
  logic [DOUT_W-1:0] shadow;
  logic [DOUT_W-1:0] sw_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  pop_cnt;
  logic [DIN_W-1:0]  din_q;
  logic              out_vld_q;

  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [CNT_W-1:0]  pop_cnt_nxt;
  logic              check_pass;
  logic              in_rdy_c;
  logic              xfer;
  logic [DIN_W-1:0]  din_next;

`ifdef ROUTE_MASK_RELAX_EN
  // Popcount of the committed mask; selects how many low din_vec bits survive.
  logic [CNT_W-1:0]  pop_used;
`endif

  // -------------------------------------------------------------------------
  // Load counters and the popcount decision
  // -------------------------------------------------------------------------
  assign bit_cnt_nxt = bit_cnt + CNT_W'(1);
  assign pop_cnt_nxt = pop_cnt + CNT_W'(cfg_bit);

`ifdef ROUTE_MASK_RELAX_EN
  assign check_pass = (pop_cnt != '0) && (pop_cnt <= CNT_W'(DIN_W));
`else
  assign check_pass = (pop_cnt == CNT_W'(DIN_W));
`endif

  // -------------------------------------------------------------------------
  // Handshake. in_rdy is combinational on out_rdy so a held word and a new
  // word can swap in the same cycle, giving full-rate streaming.
  // -------------------------------------------------------------------------
  assign in_rdy_c = (state == S_RUN) && (!out_vld_q || bus.out_rdy);
  assign xfer     = bus.in_vld && in_rdy_c;

  always_comb begin
    // NOTE: every variable written here gets a default before any condition,
    // otherwise a missed branch would infer a latch.
    din_next = bus.in_data;
`ifdef ROUTE_MASK_RELAX_EN
    for (int i = 0; i < DIN_W; i++) begin
      if (i >= int'(pop_used)) din_next[i] = 1'b0;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      // NOTE: the wide shadow and switch registers are reset explicitly: a
      // reset mid-load must not leave a partial mask that could later leak
      // into sw_vec.
      state    <= S_IDLE;
      shadow   <= '0;
      sw_q     <= '0;
      bit_cnt  <= '0;
      pop_cnt  <= '0;
      mask_ok  <= 1'b0;
      mask_err <= 1'b0;
      busy     <= 1'b0;
`ifdef ROUTE_MASK_RELAX_EN
      pop_used <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state   <= S_LOAD;
            bit_cnt <= '0;
            pop_cnt <= '0;
            mask_ok <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_LOAD: begin
          // A repeated cfg_start restarts the load; the bit presented in the
          // same cycle is discarded so the new mask starts cleanly.
          if (cfg_start) begin
            bit_cnt <= '0;
            pop_cnt <= '0;
          end else if (cfg_bit_vld) begin
            // Shift right, new bit at the MSB: after DOUT_W shifts the first
            // bit received sits at position 0.
            shadow  <= {cfg_bit, shadow[DOUT_W-1:1]};
            bit_cnt <= bit_cnt_nxt;
            pop_cnt <= pop_cnt_nxt;
            if (bit_cnt_nxt == CNT_W'(DOUT_W)) state <= S_CHECK;
          end
        end

        S_CHECK: begin
          busy <= 1'b0;
          if (check_pass) begin
            sw_q     <= shadow;
            mask_ok  <= 1'b1;
            mask_err <= 1'b0;
            state    <= S_RUN;
`ifdef ROUTE_MASK_RELAX_EN
            pop_used <= pop_cnt;
`endif
          end else begin
            mask_ok  <= 1'b0;
            mask_err <= 1'b1;
            state    <= S_ERR;
          end
        end

        S_RUN: begin
          // A transfer in this same cycle still completes in the data path.
          if (cfg_start) begin
            state <= S_DRAIN;
            busy  <= 1'b1;
          end
        end

        S_DRAIN: begin
          // sw_vec and mask_ok stay valid until the held word has left.
          if (!out_vld_q) begin
            state   <= S_LOAD;
            bit_cnt <= '0;
            pop_cnt <= '0;
            mask_ok <= 1'b0;
          end
        end

        S_ERR: begin
          if (cfg_start) begin
            state   <= S_LOAD;
            bit_cnt <= '0;
            pop_cnt <= '0;
            mask_ok <= 1'b0;
            busy    <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output data register. A new transfer wins over a drain, so a word that
  // leaves on out_rdy can be replaced in the same edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (xfer) begin
      din_q     <= din_next;
      out_vld_q <= 1'b1;
    end else if (bus.out_rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  assign bus.in_rdy  = in_rdy_c;
  assign bus.din_vec = din_q;
  assign bus.sw_vec  = sw_q;
  assign bus.out_vld = out_vld_q;

endmodule

// File: tb/tb_route_mask_ctrl.sv
// ---------------------------------------------------------------------------
// tb_route_mask_ctrl
//
// Directed bench for route_mask_ctrl: mask load / commit, popcount failure
// and recovery, streaming, back-pressure, drain ordering and mid-load reset.
// Inputs change #1 after the rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_route_mask_ctrl;

  localparam int DIN_W  = 70;
  localparam int DOUT_W = 128;
  localparam int CNT_W  = 8;

  logic clk;
  logic rst_n;
  logic cfg_start;
  logic cfg_bit;
  logic cfg_bit_vld;
  logic mask_ok;
  logic mask_err;
  logic busy;

  int n_checks;
  int n_errors;

  route_mask_ctrl_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus_if ();

  route_mask_ctrl #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_bit     (cfg_bit),
    .cfg_bit_vld (cfg_bit_vld),
    .bus         (bus_if),
    .mask_ok     (mask_ok),
    .mask_err    (mask_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] ones_mask(input int lo, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      if (i >= lo && i < lo + n) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Feed all mask bits, first bit first; the FSM must already be in LOAD.
  task automatic shift_mask(input logic [127:0] m, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      cfg_bit     = m[i];
      cfg_bit_vld = 1'b1;
      tick();
    end
    cfg_bit_vld = 1'b0;
    cfg_bit     = 1'b0;
  endtask

  // cfg_start is held two cycles: enough to pass RUN->DRAIN->LOAD when no
  // word is held, and harmless (a restart) when already in LOAD.
  task automatic load_mask(input logic [127:0] m);
    cfg_start = 1'b1;
    tick();
    tick();
    cfg_start = 1'b0;
    shift_mask(m, DOUT_W);
  endtask

  logic [127:0] lo70;
  logic [127:0] hi70;
  logic [127:0] bad_mask;
  logic [127:0] m10;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    lo70 = ones_mask(0, 70);
    hi70 = ones_mask(58, 70);
    m10  = ones_mask(0, 10);
`ifdef ROUTE_MASK_RELAX_EN
    bad_mask = ones_mask(0, 71);
`else
    bad_mask = ones_mask(0, 69);
`endif

    rst_n          = 1'b0;
    cfg_start      = 1'b0;
    cfg_bit        = 1'b0;
    cfg_bit_vld    = 1'b0;
    bus_if.in_data = '0;
    bus_if.in_vld  = 1'b1;
    bus_if.out_rdy = 1'b1;
    tick();
    tick();

    // ---- reset state ----
    check("rst_sw_vec",   128'(bus_if.sw_vec),  128'h0);
    check("rst_din_vec",  128'(bus_if.din_vec), 128'h0);
    check("rst_out_vld",  128'(bus_if.out_vld), 128'h0);
    check("rst_in_rdy",   128'(bus_if.in_rdy),  128'h0);
    check("rst_mask_ok",  128'(mask_ok),        128'h0);
    check("rst_mask_err", 128'(mask_err),       128'h0);
    check("rst_busy",     128'(busy),           128'h0);
    bus_if.in_vld = 1'b0;
    rst_n = 1'b1;
    tick();

    // ---- load 70 low ones, commit ----
    load_mask(lo70);
    check("check_busy", 128'(busy), 128'h1);
    tick();
    check("pass_sw_vec",   128'(bus_if.sw_vec), 128'h3F_FFFF_FFFF_FFFF_FFFF);
    check("pass_mask_ok",  128'(mask_ok),       128'h1);
    check("pass_mask_err", 128'(mask_err),      128'h0);
    check("run_busy",      128'(busy),          128'h0);
    check("run_in_rdy",    128'(bus_if.in_rdy), 128'h1);

    // ---- stream four words at full rate ----
    for (int k = 1; k <= 4; k++) begin
      bus_if.in_data = 70'(k);
      bus_if.in_vld  = 1'b1;
      tick();
      check($sformatf("stream_din_%0d", k), 128'(bus_if.din_vec), 128'(k));
      check($sformatf("stream_vld_%0d", k), 128'(bus_if.out_vld), 128'h1);
    end
    bus_if.in_vld = 1'b0;
    tick();
    check("stream_vld_clear", 128'(bus_if.out_vld), 128'h0);

    // ---- back-pressure ----
    bus_if.in_data = 70'h2A;
    bus_if.in_vld  = 1'b1;
    tick();
    check("bp_first", 128'(bus_if.din_vec), 128'h2A);
    bus_if.out_rdy = 1'b0;
    bus_if.in_data = 70'h55;
    #1;
    check("bp_in_rdy_low", 128'(bus_if.in_rdy), 128'h0);
    tick();
    check("bp_hold_1", 128'(bus_if.din_vec), 128'h2A);
    tick();
    check("bp_hold_2", 128'(bus_if.din_vec), 128'h2A);
    check("bp_hold_vld", 128'(bus_if.out_vld), 128'h1);
    bus_if.out_rdy = 1'b1;
    #1;
    check("bp_in_rdy_high", 128'(bus_if.in_rdy), 128'h1);
    tick();
    check("bp_next_word", 128'(bus_if.din_vec), 128'h55);
    check("bp_next_vld",  128'(bus_if.out_vld), 128'h1);
    bus_if.in_vld = 1'b0;
    tick();
    check("bp_vld_clear", 128'(bus_if.out_vld), 128'h0);

    // ---- cfg_start with a held word: drain before loading ----
    bus_if.in_data = 70'h77;
    bus_if.in_vld  = 1'b1;
    tick();
    bus_if.in_vld  = 1'b0;
    bus_if.out_rdy = 1'b0;
    cfg_start      = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("drain_busy",    128'(busy),           128'h1);
    check("drain_held",    128'(bus_if.din_vec), 128'h77);
    check("drain_vld",     128'(bus_if.out_vld), 128'h1);
    tick();
    check("drain_wait_vld", 128'(bus_if.out_vld), 128'h1);
    check("drain_wait_ok",  128'(mask_ok),        128'h1);
    bus_if.out_rdy = 1'b1;
    bus_if.in_data = 70'h99;
    bus_if.in_vld  = 1'b1;
    #1;
    check("drain_in_rdy", 128'(bus_if.in_rdy), 128'h0);
    tick();
    bus_if.in_vld = 1'b0;
    check("drain_vld_gone", 128'(bus_if.out_vld), 128'h0);
    check("drain_din_kept", 128'(bus_if.din_vec), 128'h77);
    check("drain_ok_still", 128'(mask_ok),        128'h1);
    tick();
    check("load_mask_ok_clr", 128'(mask_ok), 128'h0);
    check("load_busy",        128'(busy),    128'h1);

    // ---- bad popcount ----
    shift_mask(bad_mask, DOUT_W);
    tick();
    check("err_mask_err", 128'(mask_err),       128'h1);
    check("err_mask_ok",  128'(mask_ok),        128'h0);
    check("err_busy",     128'(busy),           128'h0);
    check("err_sw_kept",  128'(bus_if.sw_vec),  lo70);
    check("err_out_vld",  128'(bus_if.out_vld), 128'h0);
    bus_if.in_vld = 1'b1;
    #1;
    check("err_in_rdy", 128'(bus_if.in_rdy), 128'h0);
    bus_if.in_vld = 1'b0;

    // ---- recover with a different valid mask ----
    load_mask(hi70);
    tick();
    check("rec_sw_vec",   128'(bus_if.sw_vec), hi70);
    check("rec_mask_ok",  128'(mask_ok),       128'h1);
    check("rec_mask_err", 128'(mask_err),      128'h0);

    // ---- reset after 60 mask bits ----
    cfg_start = 1'b1;
    tick();
    tick();
    cfg_start = 1'b0;
    shift_mask(lo70, 60);
    check("midload_busy", 128'(busy), 128'h1);
    rst_n = 1'b0;
    tick();
    check("mrst_sw_vec",   128'(bus_if.sw_vec),  128'h0);
    check("mrst_din_vec",  128'(bus_if.din_vec), 128'h0);
    check("mrst_out_vld",  128'(bus_if.out_vld), 128'h0);
    check("mrst_mask_ok",  128'(mask_ok),        128'h0);
    check("mrst_mask_err", 128'(mask_err),       128'h0);
    check("mrst_busy",     128'(busy),           128'h0);
    check("mrst_in_rdy",   128'(bus_if.in_rdy),  128'h0);
    rst_n = 1'b1;
    tick();
    load_mask(lo70);
    tick();
    check("fresh_sw_vec",  128'(bus_if.sw_vec), lo70);
    check("fresh_mask_ok", 128'(mask_ok),       128'h1);

    // ---- full-width data with a 70-bit mask passes unmodified ----
    bus_if.in_data = '1;
    bus_if.in_vld  = 1'b1;
    tick();
    bus_if.in_vld = 1'b0;
    check("full_word", 128'(bus_if.din_vec), 128'h3F_FFFF_FFFF_FFFF_FFFF);
    tick();

    // ---- popcount-10 mask ----
    load_mask(m10);
    tick();
`ifdef ROUTE_MASK_RELAX_EN
    check("relax_mask_ok", 128'(mask_ok),       128'h1);
    check("relax_sw_vec",  128'(bus_if.sw_vec), m10);
    bus_if.in_data = '1;
    bus_if.in_vld  = 1'b1;
    tick();
    bus_if.in_vld = 1'b0;
    check("relax_din_vec", 128'(bus_if.din_vec), 128'h3FF);
`else
    check("strict10_mask_err", 128'(mask_err),      128'h1);
    check("strict10_mask_ok",  128'(mask_ok),       128'h0);
    check("strict10_sw_kept",  128'(bus_if.sw_vec), lo70);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/route_mask_ctrl.md
Name: route_mask_ctrl

Overview:
- Control and data-staging stage directly upstream of the route-distributor combinational chain.
- Serially loads a DOUT_W-bit lane-switch mask, validates its population count, and commits it to the active mask register.
- Accepts DIN_W-bit data words through a valid/ready handshake and presents them, registered, with the stable switch vector to the distributor chain.
- Distributor chain consumes din_vec and sw_vec; sw_vec[i] drives the sw input of chain cell i.

Parameters:
- DIN_W, 70, data word width; also the required mask popcount.
- DOUT_W, 128, output lane count; also the mask length.
- CNT_W, 8, width of the bit counter and popcount counter; must satisfy 2^CNT_W > DOUT_W.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- cfg_start  input  1  pulse: begin a new mask load.
- cfg_bit  input  1  serial mask bit.
- cfg_bit_vld  input  1  cfg_bit qualifier.
- in_data  input  DIN_W  data word.
- in_vld  input  1  in_data valid.
- in_rdy  output  1  block accepts in_data.
- din_vec  output  DIN_W  registered data to the distributor.
- sw_vec  output  DOUT_W  active lane-switch mask.
- out_vld  output  1  din_vec valid.
- out_rdy  input  1  downstream accepts din_vec.
- mask_ok  output  1  active mask committed and valid.
- mask_err  output  1  last load failed its popcount check.
- busy  output  1  high in LOAD, CHECK or DRAIN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - sw_vec, din_vec, the shadow mask, and both counters clear to 0.
  - out_vld, mask_ok, mask_err and busy clear to 0.
  - in_rdy is 0.
- Reset mid-load or mid-drain: any partial mask and any held output word are discarded.
- States:
  - IDLE: wait for cfg_start; go to LOAD.
  - LOAD: on each cycle with cfg_bit_vld=1, the shadow mask shifts right with cfg_bit entering the MSB. The bit counter increments; the popcount counter increments when cfg_bit=1. When the bit counter reaches DOUT_W, go to CHECK. The first received bit therefore ends at sw_vec[0].
  - CHECK (1 cycle):
    - Popcount == DIN_W: copy the shadow mask to sw_vec, set mask_ok=1 and mask_err=0, go to RUN.
    - Otherwise: set mask_ok=0 and mask_err=1, go to ERR. sw_vec keeps its previous value.
  - RUN: data path active (see below). cfg_start → DRAIN.
  - DRAIN: in_rdy=0. When out_vld=0, clear the counters and go to LOAD.
  - ERR: in_rdy=0 and out_vld=0. cfg_start → LOAD with counters cleared.
- Entering LOAD from any state clears mask_ok.
- cfg_start while in LOAD restarts the load: counters clear and the shadow mask is overwritten as new bits arrive.
- cfg_bit_vld is ignored outside LOAD. cfg_start is ignored in CHECK.
- Data path:
  - in_rdy = (state==RUN) && (!out_vld || out_rdy).
  - A transfer occurs when in_vld && in_rdy. din_vec <= in_data and out_vld <= 1 on the following edge; latency is 1 cycle.
  - out_vld clears on out_rdy when no new transfer occurs in that cycle.
  - Back-to-back transfers are supported at full rate while out_rdy=1.
  - din_vec holds stable while out_vld && !out_rdy.
- Simultaneous events:
  - cfg_start together with an in_vld/in_rdy transfer in RUN: the transfer completes, then the block enters DRAIN.
  - In DRAIN, the held word leaves on out_rdy before the new load begins.
- busy = state ∈ {LOAD, CHECK, DRAIN}.
- sw_vec changes only in CHECK on a pass, so it is constant whenever out_vld=1.

Optional Feature:
- Macro: ROUTE_MASK_RELAX_EN.
- Defined:
  - CHECK passes for 1 ≤ popcount ≤ DIN_W.
  - The committed popcount P is stored.
  - In-data bits [DIN_W-1:P] are forced to 0 in din_vec on every transfer, so unused distributor inputs are deterministic.
  - Popcount 0 or greater than DIN_W → ERR.
- Undefined:
  - Only popcount == DIN_W passes.
  - din_vec is an unmodified copy of in_data.

Test Plan:
- Reset, then load a mask of 70 ones followed by 58 zeros (bits 0..69 = 1) → CHECK passes; sw_vec = {58'b0, 70'h3F_FFFF_FFFF_FFFF_FFFF}; mask_ok=1; busy=0 in RUN.
- Load a mask with popcount 69 → mask_err=1, mask_ok=0, in_rdy=0, sw_vec unchanged. Then cfg_start with a valid 70-one mask → recovers to RUN.
- In RUN with out_rdy=1, stream 4 words (0x1, 0x2, 0x3, 0x4) on consecutive cycles → each appears on din_vec 1 cycle later; out_vld stays high for 4 cycles.
- out_rdy=0 with one word held (0x2A) and in_vld=1 → in_rdy=0 and din_vec stays 0x2A. Raise out_rdy → the next word is accepted in that same cycle.
- Assert cfg_start in RUN while out_vld=1 and out_rdy=0 → DRAIN and busy=1. LOAD starts only after out_rdy clears the held word.
- rst_n=0 after 60 mask bits have been loaded → all outputs 0 and state IDLE. A fresh 128-bit load then completes normally.
- With ROUTE_MASK_RELAX_EN: mask popcount 10, in_data all ones → din_vec = 0x3FF.
